// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_VALID
    } fetch_state_e;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP            = 32'h0000_0013;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory read channel between the fetch unit and memory.
interface pc_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/pc_fetch_next_pc_sel.sv
// Next-PC priority mux: JALR over branch over sequential, with word alignment
// forced on the result and a flag raised when the raw target was misaligned.
module next_pc_sel (
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jalr_taken,
    input  logic [31:0] jalr_target,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] target;

    always_comb begin
        target = pc_plus4;
        if (jalr_taken) begin
            target = {jalr_target[31:1], 1'b0};
        end else if (branch_taken) begin
            target = branch_target;
        end
    end

    assign misalign = |target[1:0];
    assign next_pc  = {target[31:2], 2'b00};

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch unit: BOOT/FETCH/VALID sequencer, PC register, fetched
// instruction register and retired-instruction counter.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              jalr_taken,
    input  logic [31:0]       jalr_target,
    pc_fetch_if.master        imem,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              misalign,
    output logic [31:0]       instret
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic        take_fetch;
    logic        retire;
    logic [31:0] sel_pc;
    logic        sel_misalign;

    assign pc_plus4       = pc + 32'd4;
    assign imem.imem_addr = pc;

    next_pc_sel u_next_pc_sel (
        .pc_plus4      (pc_plus4),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jalr_taken    (jalr_taken),
        .jalr_target   (jalr_target),
        .next_pc       (sel_pc),
        .misalign      (sel_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Acks outside FETCH and redirects outside the retire cycle have no effect.
    always_comb begin
        state_d       = state_q;
        imem.imem_req = 1'b0;
        take_fetch    = 1'b0;
        retire        = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ack) begin
                    take_fetch = 1'b1;
                    state_d    = ST_VALID;
                end
            end
            ST_VALID: begin
                if (!stall) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_VECTOR;
            instr       <= INSTR_NOP;
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
            instret     <= 32'd0;
        end else begin
            misalign <= retire & sel_misalign;
            if (take_fetch) begin
                instr       <= imem.imem_rdata;
                instr_valid <= 1'b1;
            end
            if (retire) begin
                pc          <= sel_pc;
                instret     <= instret + 32'd1;
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a table of fetch/retire records plus
// hand-written stall and reset-during-fetch sequences.
module tb_pc_fetch;
    import pc_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jalr_taken;
    logic [31:0] jalr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misalign;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    pc_fetch_if imem_bus ();

    pc_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jalr_taken    (jalr_taken),
        .jalr_target   (jalr_target),
        .imem          (imem_bus.master),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .misalign      (misalign),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        br;
        logic [31:0] br_tgt;
        logic        jr;
        logic [31:0] jr_tgt;
        logic [31:0] exp_next;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (imem_bus.imem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("req_wait", {31'd0, imem_bus.imem_req}, 32'd1);
    endtask

    task automatic clear_redirects();
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        jalr_taken    = 1'b0;
        jalr_target   = 32'd0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0, 32'h0,         1'b0, 32'h0,   32'h0000_0004, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h0000_0013, 1'b1, 32'h10,        1'b0, 32'h0,   32'h0000_0010, 1'b0};
        vecs[2] = '{32'h0000_0010, 32'h0010_0113, 1'b0, 32'h0,         1'b0, 32'h0,   32'h0000_0014, 1'b0};
        vecs[3] = '{32'h0000_0014, 32'h0020_0193, 1'b1, 32'h40,        1'b1, 32'h81,  32'h0000_0080, 1'b0};
        vecs[4] = '{32'h0000_0080, 32'h0030_0213, 1'b1, 32'h42,        1'b0, 32'h0,   32'h0000_0040, 1'b1};
        vecs[5] = '{32'h0000_0040, 32'h0040_0293, 1'b0, 32'h0,         1'b1, 32'h103, 32'h0000_0100, 1'b1};
        vecs[6] = '{32'h0000_0100, 32'h0050_0313, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,   32'hFFFF_FFFC, 1'b0};
        vecs[7] = '{32'hFFFF_FFFC, 32'h0060_0393, 1'b0, 32'h0,         1'b0, 32'h0,   32'h0000_0000, 1'b0};

        rst                 = 1'b1;
        stall               = 1'b0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'd0;
        clear_redirects();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_instret", instret, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            wait_req();
            check($sformatf("v%0d_addr", i), imem_bus.imem_addr, vecs[i].addr);
            check($sformatf("v%0d_pc_plus4", i), pc_plus4, vecs[i].addr + 32'd4);
            imem_bus.imem_ack   = 1'b1;
            imem_bus.imem_rdata = vecs[i].rdata;
            @(negedge clk);
            imem_bus.imem_ack = 1'b0;
            check($sformatf("v%0d_instr", i), instr, vecs[i].rdata);
            check($sformatf("v%0d_valid", i), {31'd0, instr_valid}, 32'd1);
            check($sformatf("v%0d_req_low", i), {31'd0, imem_bus.imem_req}, 32'd0);
            check($sformatf("v%0d_instret_pre", i), instret, i);
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].br_tgt;
            jalr_taken    = vecs[i].jr;
            jalr_target   = vecs[i].jr_tgt;
            @(negedge clk);
            clear_redirects();
            check($sformatf("v%0d_next_pc", i), pc, vecs[i].exp_next);
            check($sformatf("v%0d_misalign", i), {31'd0, misalign}, {31'd0, vecs[i].exp_mis});
            check($sformatf("v%0d_instret", i), instret, i + 1);
            check($sformatf("v%0d_valid_clr", i), {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_misalign_end", i), {31'd0, misalign}, 32'd0);
        end

        // Stall for five cycles while toggling redirects, then retire.
        wait_req();
        check("stall_addr", imem_bus.imem_addr, 32'h0);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h00A0_0113;
        @(negedge clk);
        imem_bus.imem_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            stall         = 1'b1;
            branch_taken  = k[0];
            branch_target = 32'h200 + k;
            jalr_taken    = k[1];
            jalr_target   = 32'h300 + k;
            @(negedge clk);
            check($sformatf("stall%0d_pc", k), pc, 32'h0);
            check($sformatf("stall%0d_instr", k), instr, 32'h00A0_0113);
            check($sformatf("stall%0d_instret", k), instret, 32'd8);
            check($sformatf("stall%0d_valid", k), {31'd0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        clear_redirects();
        @(negedge clk);
        check("stall_retire_pc", pc, 32'h4);
        check("stall_retire_instret", instret, 32'd9);
        check("stall_retire_misalign", {31'd0, misalign}, 32'd0);

        // Reset while a request is outstanding; the following ack is discarded.
        wait_req();
        check("rstf_addr", imem_bus.imem_addr, 32'h4);
        rst = 1'b1;
        @(negedge clk);
        rst                 = 1'b0;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        check("rstf_pc", pc, 32'h0);
        check("rstf_req_boot", {31'd0, imem_bus.imem_req}, 32'd0);
        check("rstf_valid", {31'd0, instr_valid}, 32'd0);
        check("rstf_instret", instret, 32'd0);
        @(negedge clk);
        imem_bus.imem_ack = 1'b0;
        check("rstf_instr_nop", instr, 32'h0000_0013);
        check("rstf_valid_after_ack", {31'd0, instr_valid}, 32'd0);
        check("rstf_req_fetch", {31'd0, imem_bus.imem_req}, 32'd1);
        check("rstf_addr_after", imem_bus.imem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
